// File: rtl/flicker_pwm.sv
// flicker_pwm: candle brightness engine.
// Fetches 4 random bits from an external LFSR, turns the nibble into a target
// brightness (clamped to FLOOR), ramps the current level one step per PWM
// frame toward it, dwells for HOLD_FRAMES frames, then fetches again.
// The level drives a 16-step PWM waveform on pwm_out.
//
// Handshake: rnd_req is a plain level request, high only while in FETCH.
// The LFSR shifts on every clock edge where rnd_req is high, so FETCH lasts
// exactly 4 cycles to bring in 4 fresh bits. rnd_in is read one cycle later
// in SAMPLE, after the last shift has settled.
module flicker_pwm #(
  parameter int         HOLD_FRAMES = 8,
  parameter logic [3:0] FLOOR       = 4'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] rnd_in,
  output logic       rnd_req,
  output logic [3:0] level,
  output logic       pwm_out,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_SAMPLE = 3'd2,
    S_RAMP   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [3:0] target_q, target_d;
  logic [3:0] pwm_cnt_q, pwm_cnt_d;
  logic [1:0] fetch_cnt_q, fetch_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       frame_end;

  assign frame_end = (pwm_cnt_q == 4'd15);

  // State and datapath registers; everything clears on asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      level_q     <= 4'd0;
      target_q    <= 4'd0;
      pwm_cnt_q   <= 4'd0;
      fetch_cnt_q <= 2'd0;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      target_q    <= target_d;
      pwm_cnt_q   <= pwm_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Next-state logic: run=0 wins in every state and freezes level/target.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    target_d    = target_q;
    fetch_cnt_d = fetch_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    // PWM counter free-runs in every state, wrapping 15 -> 0.
    pwm_cnt_d   = pwm_cnt_q + 4'd1;

    if (!run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_FETCH;
          fetch_cnt_d = 2'd0;
        end
        S_FETCH: begin
          if (fetch_cnt_q == 2'd3) begin
            state_d = S_SAMPLE;
          end else begin
            fetch_cnt_d = fetch_cnt_q + 2'd1;
          end
        end
        S_SAMPLE: begin
          target_d = (rnd_in < FLOOR) ? FLOOR : rnd_in;
          state_d  = S_RAMP;
        end
        S_RAMP: begin
          // Level only moves on a frame boundary so every frame is whole.
          if (frame_end) begin
            if (level_q == target_q) begin
              state_d    = S_HOLD;
              hold_cnt_d = 8'd0;
            end else if (level_q < target_q) begin
              level_d = level_q + 4'd1;
            end else begin
              level_d = level_q - 4'd1;
            end
          end
        end
        S_HOLD: begin
          if (frame_end) begin
            if (hold_cnt_q + 8'd1 == HOLD_LAST) begin
              state_d     = S_FETCH;
              fetch_cnt_d = 2'd0;
            end else begin
              hold_cnt_d = hold_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign rnd_req     = (state_q == S_FETCH);
  assign pwm_out     = (pwm_cnt_q < level_q);
  assign level       = level_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_flicker_pwm.sv
// Directed bench for flicker_pwm: reset, fetch/sample with clamping,
// up/down ramps, hold duration, run drop, reset mid-hold and an LFSR run.
module tb_flicker_pwm;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_RAMP   = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  logic       clk;
  logic       reset;
  logic       run;
  logic [3:0] rnd_in;
  logic       rnd_req;
  logic [3:0] level;
  logic       pwm_out;
  logic [2:0] dbg_state;

  logic [3:0]  rnd_direct;
  logic        use_lfsr;
  logic [15:0] lfsr_q;
  logic [3:0]  m_cnt;

  int n_cmp;
  int n_fail;

  flicker_pwm #(.HOLD_FRAMES(8), .FLOOR(4'd6)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .rnd_in     (rnd_in),
    .rnd_req    (rnd_req),
    .level      (level),
    .pwm_out    (pwm_out),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural LFSR: Fibonacci, taps 16/14/13/11, shifts left on request.
  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hbeef;
    else if (rnd_req) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign rnd_in = use_lfsr ? lfsr_q[3:0] : rnd_direct;

  // Reference PWM phase counter, restarted by reset.
  always @(posedge clk or posedge reset) begin
    if (reset) m_cnt <= 4'd0;
    else m_cnt <= m_cnt + 4'd1;
  end

  // Driver / wait tasks (bounded)
  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic count_req(output int n);
    n = 0;
    while (rnd_req === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_level_change(input logic [3:0] prev, output int n);
    n = 0;
    while (level === prev && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (dbg_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    run = 1'b0;
    rnd_direct = 4'd0;
    use_lfsr = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (rnd_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", rnd_req); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++; if (rnd_req !== 1'b0) begin n_fail++; $display("FAIL idle_req cyc %0d: got %b want 0", i, rnd_req); end
      n_cmp++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL idle_pwm cyc %0d: got %b want 0", i, pwm_out); end
    end
  endtask

  // Four back-to-back fetch/ramp/hold rounds: up to 11, clamp to 6, up to 11, down to 7.
  task automatic test_fetch_sample();
    logic [3:0] vals [4];
    logic [3:0] tgts [4];
    logic [3:0] cur;
    logic [3:0] nxt;
    int n;
    int duty;
    vals = '{4'hB, 4'h2, 4'hB, 4'h7};
    tgts = '{4'd11, 4'd6, 4'd11, 4'd7};
    cur = 4'd0;
    for (int i = 0; i < 4; i++) begin
      rnd_direct = vals[i];
      if (i == 0) begin
        run = 1'b1;
        @(negedge clk);
      end
      count_req(n);
      n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL fetch_len r%0d: got %0d want 4", i, n); end
      n_cmp++; if (dbg_state !== ST_SAMPLE) begin n_fail++; $display("FAIL sample_state r%0d: got %0d want %0d", i, dbg_state, ST_SAMPLE); end
      @(negedge clk);
      n_cmp++; if (dbg_state !== ST_RAMP) begin n_fail++; $display("FAIL ramp_state r%0d: got %0d want %0d", i, dbg_state, ST_RAMP); end
      while (cur != tgts[i]) begin
        nxt = (cur < tgts[i]) ? cur + 4'd1 : cur - 4'd1;
        wait_level_change(cur, n);
        n_cmp++; if (level !== nxt) begin n_fail++; $display("FAIL ramp_step r%0d: got %0d want %0d", i, level, nxt); end
        n_cmp++; if (m_cnt !== 4'd0) begin n_fail++; $display("FAIL ramp_phase r%0d: got pwm_cnt %0d want 0", i, m_cnt); end
        cur = nxt;
      end
      wait_state(ST_HOLD, 40, n);
      n_cmp++; if (n !== 16) begin n_fail++; $display("FAIL hold_entry r%0d: got %0d cycles want 16", i, n); end
      n_cmp++; if (level !== tgts[i]) begin n_fail++; $display("FAIL hold_level r%0d: got %0d want %0d", i, level, tgts[i]); end
      n = 0;
      duty = 0;
      while (dbg_state === ST_HOLD && n < 300) begin
        if (n < 16) duty += int'(pwm_out);
        @(negedge clk);
        n++;
      end
      n_cmp++; if (duty !== int'(tgts[i])) begin n_fail++; $display("FAIL hold_duty r%0d: got %0d want %0d", i, duty, tgts[i]); end
      n_cmp++; if (n !== 128) begin n_fail++; $display("FAIL hold_len r%0d: got %0d want 128", i, n); end
      n_cmp++; if (dbg_state !== ST_FETCH) begin n_fail++; $display("FAIL refetch r%0d: got %0d want %0d", i, dbg_state, ST_FETCH); end
    end
    run = 1'b0;
    @(negedge clk);
    n_cmp++; if (rnd_req !== 1'b0) begin n_fail++; $display("FAIL stop_req: got %b want 0", rnd_req); end
    n_cmp++; if (level !== 4'd7) begin n_fail++; $display("FAIL stop_level: got %0d want 7", level); end
  endtask

  // run dropped at level 4 heading to 9; level freezes, PWM keeps 4/16.
  task automatic test_run_drop();
    logic [3:0] cur;
    int n;
    int high;
    int bad;
    pulse_reset();
    rnd_direct = 4'h9;
    run = 1'b1;
    @(negedge clk);
    count_req(n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL drop_fetch1: got %0d want 4", n); end
    cur = 4'd0;
    for (int s = 1; s <= 4; s++) begin
      wait_level_change(cur, n);
      n_cmp++; if (level !== 4'(s)) begin n_fail++; $display("FAIL drop_climb: got %0d want %0d", level, s); end
      cur = 4'(s);
    end
    run = 1'b0;
    @(negedge clk);
    n_cmp++; if (rnd_req !== 1'b0) begin n_fail++; $display("FAIL drop_req: got %b want 0", rnd_req); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL drop_state: got %0d want %0d", dbg_state, ST_IDLE); end
    high = 0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      high += int'(pwm_out);
      if (level !== 4'd4 || rnd_req !== 1'b0 || pwm_out !== (m_cnt < 4'd4)) bad++;
      @(negedge clk);
    end
    n_cmp++; if (high !== 16) begin n_fail++; $display("FAIL drop_duty: got %0d high of 64 want 16", high); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL drop_frozen: got %0d bad cycles want 0", bad); end
    run = 1'b1;
    @(negedge clk);
    count_req(n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL drop_fetch2: got %0d want 4", n); end
    n_cmp++; if (dbg_state !== ST_SAMPLE) begin n_fail++; $display("FAIL drop_sample: got %0d want %0d", dbg_state, ST_SAMPLE); end
    for (int s = 5; s <= 9; s++) begin
      wait_level_change(cur, n);
      n_cmp++; if (level !== 4'(s)) begin n_fail++; $display("FAIL drop_reclimb: got %0d want %0d", level, s); end
      cur = 4'(s);
    end
    wait_state(ST_HOLD, 40, n);
    n_cmp++; if (n !== 16) begin n_fail++; $display("FAIL drop_hold_entry: got %0d want 16", n); end
  endtask

  // Reset asserted in HOLD at level 9: immediate clear, PWM phase restarts.
  task automatic test_reset_mid_hold();
    logic [3:0] cur;
    int n;
    repeat (20) @(negedge clk);
    n_cmp++; if (level !== 4'd9) begin n_fail++; $display("FAIL mid_pre_level: got %0d want 9", level); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL mid_level: got %0d want 0", level); end
    n_cmp++; if (pwm_out !== 1'b0) begin n_fail++; $display("FAIL mid_pwm: got %b want 0", pwm_out); end
    n_cmp++; if (rnd_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b want 0", rnd_req); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL mid_state: got %0d want %0d", dbg_state, ST_IDLE); end
    rnd_direct = 4'hB;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    count_req(n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL mid_fetch: got %0d want 4", n); end
    cur = 4'd0;
    for (int s = 1; s <= 3; s++) begin
      wait_level_change(cur, n);
      n_cmp++; if (level !== 4'(s)) begin n_fail++; $display("FAIL mid_climb: got %0d want %0d", level, s); end
      n_cmp++; if (m_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_phase: got pwm_cnt %0d want 0", m_cnt); end
      cur = 4'(s);
    end
    run = 1'b0;
  endtask

  // LFSR seeded 16'hbeef: first sample is 6, so level settles at 6.
  task automatic test_lfsr();
    logic [3:0] cur;
    int n;
    int duty;
    pulse_reset();
    use_lfsr = 1'b1;
    run = 1'b1;
    @(negedge clk);
    count_req(n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL lfsr_fetch: got %0d want 4", n); end
    cur = 4'd0;
    for (int s = 1; s <= 6; s++) begin
      wait_level_change(cur, n);
      n_cmp++; if (level !== 4'(s)) begin n_fail++; $display("FAIL lfsr_climb: got %0d want %0d", level, s); end
      cur = 4'(s);
    end
    wait_state(ST_HOLD, 40, n);
    n_cmp++; if (n !== 16) begin n_fail++; $display("FAIL lfsr_hold_entry: got %0d want 16", n); end
    duty = 0;
    for (int i = 0; i < 16; i++) begin
      duty += int'(pwm_out);
      @(negedge clk);
    end
    n_cmp++; if (duty !== 6) begin n_fail++; $display("FAIL lfsr_duty: got %0d want 6", duty); end
    n_cmp++; if (level !== 4'd6) begin n_fail++; $display("FAIL lfsr_level: got %0d want 6", level); end
    run = 1'b0;
    use_lfsr = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_fetch_sample();
    test_run_drop();
    test_reset_mid_hold();
    test_lfsr();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
